// File: rtl/sync_fifo_param_if.sv
// rtl/sync_fifo_param_if.sv - producer/consumer bundle for sync_fifo_param.
// master drives requests and write data; slave is the FIFO side.
interface sync_fifo_param_if #(
  parameter int DW = 8,
  parameter int AW = 4
);
  logic          flush;
  logic          write_rq;
  logic [DW-1:0] data_in;
  logic          read_rq;
  logic [DW-1:0] data_out;
  logic          data_valid;
  logic          empty;
  logic          almost_empty;
  logic          full;
  logic          almost_full;
  logic [AW:0]   count;
  logic          overflow;
  logic          underflow;

  modport master (
    output flush, write_rq, data_in, read_rq,
    input  data_out, data_valid, empty, almost_empty, full, almost_full,
           count, overflow, underflow
  );

  modport slave (
    input  flush, write_rq, data_in, read_rq,
    output data_out, data_valid, empty, almost_empty, full, almost_full,
           count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_param.sv
// rtl/sync_fifo_param.sv - single-clock FIFO, DEPTH=2**AW, count, thresholds, flush.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads; default is registered read.
module sync_fifo_param #(
  parameter int DW     = 8,
  parameter int AW     = 4,
  parameter int AE_LVL = 1,
  parameter int AF_LVL = 2**AW - 1
) (
  input  logic            clk,
  input  logic            rst,
  sync_fifo_param_if.slave fifo
);
  localparam int          DEPTH   = 2**AW;
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] AE_C    = (AW+1)'(AE_LVL);
  localparam logic [AW:0] AF_C    = (AW+1)'(AF_LVL);

  logic [DW-1:0] mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic [AW:0]   occ;
  logic          is_empty;
  logic          is_full;
  logic          wr_acc;
  logic          rd_acc;
  logic          overflow_q;
  logic          underflow_q;

  // Extra pointer bit distinguishes full from empty, so all DEPTH entries are usable.
  assign occ      = wr_ptr - rd_ptr;
  assign is_empty = (occ == '0);
  assign is_full  = (occ == DEPTH_C);

  // Flush wins over both requests in the same cycle.
  assign wr_acc = fifo.write_rq & ~is_full  & ~fifo.flush;
  assign rd_acc = fifo.read_rq  & ~is_empty & ~fifo.flush;

  assign fifo.count        = occ;
  assign fifo.empty        = is_empty;
  assign fifo.full         = is_full;
  assign fifo.almost_empty = (occ <= AE_C);
  assign fifo.almost_full  = (occ >= AF_C);
  assign fifo.overflow     = overflow_q;
  assign fifo.underflow    = underflow_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= fifo.write_rq & is_full  & ~fifo.flush;
      underflow_q <= fifo.read_rq  & is_empty & ~fifo.flush;
      if (fifo.flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
        if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr[AW-1:0]] <= fifo.data_in;
  end

`ifdef SYNC_FIFO_FWFT_EN
  assign fifo.data_out   = mem[rd_ptr[AW-1:0]];
  assign fifo.data_valid = ~is_empty;
`else
  logic [DW-1:0] dout_q;
  logic          dv_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_q <= '0;
      dv_q   <= 1'b0;
    end else begin
      dv_q <= rd_acc;
      if (rd_acc) dout_q <= mem[rd_ptr[AW-1:0]];
    end
  end

  assign fifo.data_out   = dout_q;
  assign fifo.data_valid = dv_q;
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// tb/tb_sync_fifo_param.sv - bench for sync_fifo_param, DW=8 AW=2.
// Directed vector table plus random traffic against a queue model.
module tb_sync_fifo_param;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  sync_fifo_param_if #(.DW(8), .AW(2)) bus ();

  sync_fifo_param #(.DW(8), .AW(2), .AE_LVL(1), .AF_LVL(3)) dut (
    .clk  (clk),
    .rst  (rst),
    .fifo (bus)
  );

  typedef struct {
    logic       fl, wr, rd;
    logic [7:0] din;
    int         cnt;
    logic       emp, ae, ful, af, dv;
    logic [7:0] dout;
    logic       ovf, unf;
  } vec_t;

  vec_t       tbl [$];
  logic [7:0] q [$];
  logic [7:0] m_dout;
  logic       m_dv;
  logic       m_ovf, m_unf;

  function automatic vec_t mk(logic fl, logic wr, logic rd, logic [7:0] din, int cnt,
                              logic emp, logic ae, logic ful, logic af, logic dv,
                              logic [7:0] dout, logic ovf, logic unf);
    vec_t v;
    v.fl = fl; v.wr = wr; v.rd = rd; v.din = din; v.cnt = cnt;
    v.emp = emp; v.ae = ae; v.ful = ful; v.af = af; v.dv = dv;
    v.dout = dout; v.ovf = ovf; v.unf = unf;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic fl, input logic wr, input logic rd, input logic [7:0] d);
    bus.flush    = fl;
    bus.write_rq = wr;
    bus.read_rq  = rd;
    bus.data_in  = d;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, ".count"}, 32'(bus.count), 0);
    chk({tag, ".empty"}, 32'(bus.empty), 1);
    chk({tag, ".almost_empty"}, 32'(bus.almost_empty), 1);
    chk({tag, ".full"}, 32'(bus.full), 0);
    chk({tag, ".almost_full"}, 32'(bus.almost_full), 0);
    chk({tag, ".data_valid"}, 32'(bus.data_valid), 0);
    chk({tag, ".overflow"}, 32'(bus.overflow), 0);
    chk({tag, ".underflow"}, 32'(bus.underflow), 0);
`ifndef SYNC_FIFO_FWFT_EN
    chk({tag, ".data_out"}, 32'(bus.data_out), 0);
`endif
  endtask

  // Model: plain queue with pop-then-push, decisions taken on pre-edge occupancy.
  task automatic rand_step(input int n, input logic fl, input logic wr, input logic rd,
                           input logic [7:0] d);
    int sz;
    sz = q.size();
    drive(fl, wr, rd, d);
    m_ovf = !fl && wr && (sz == DEPTH);
    m_unf = !fl && rd && (sz == 0);
    if (fl) begin
      q.delete();
      m_dv = 1'b0;
    end else begin
      if (rd && sz > 0) begin
        m_dout = q.pop_front();
        m_dv   = 1'b1;
      end else begin
        m_dv = 1'b0;
      end
      if (wr && sz < DEPTH) q.push_back(d);
    end
    @(posedge clk);
    #1;
    chk($sformatf("rnd%0d.count", n), 32'(bus.count), 32'(q.size()));
    chk($sformatf("rnd%0d.empty", n), 32'(bus.empty), 32'(q.size() == 0));
    chk($sformatf("rnd%0d.full", n), 32'(bus.full), 32'(q.size() == DEPTH));
    chk($sformatf("rnd%0d.almost_empty", n), 32'(bus.almost_empty), 32'(q.size() <= 1));
    chk($sformatf("rnd%0d.almost_full", n), 32'(bus.almost_full), 32'(q.size() >= 3));
    chk($sformatf("rnd%0d.overflow", n), 32'(bus.overflow), 32'(m_ovf));
    chk($sformatf("rnd%0d.underflow", n), 32'(bus.underflow), 32'(m_unf));
`ifdef SYNC_FIFO_FWFT_EN
    chk($sformatf("rnd%0d.data_valid", n), 32'(bus.data_valid), 32'(q.size() > 0));
    if (q.size() > 0) chk($sformatf("rnd%0d.data_out", n), 32'(bus.data_out), 32'(q[0]));
`else
    chk($sformatf("rnd%0d.data_valid", n), 32'(bus.data_valid), 32'(m_dv));
    chk($sformatf("rnd%0d.data_out", n), 32'(bus.data_out), 32'(m_dout));
`endif
  endtask

  initial begin
    drive(0, 0, 0, 8'h00);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check_reset_values("reset");

`ifndef SYNC_FIFO_FWFT_EN
    //     fl wr rd din    cnt emp ae ful af dv dout   ovf unf
    tbl.push_back(mk(0, 1, 0, 8'h11, 1, 0, 1, 0, 0, 0, 8'h00, 0, 0));
    tbl.push_back(mk(0, 1, 0, 8'h22, 2, 0, 0, 0, 0, 0, 8'h00, 0, 0));
    tbl.push_back(mk(0, 1, 0, 8'h33, 3, 0, 0, 0, 1, 0, 8'h00, 0, 0));
    tbl.push_back(mk(0, 1, 0, 8'h44, 4, 0, 0, 1, 1, 0, 8'h00, 0, 0));
    tbl.push_back(mk(0, 0, 1, 8'h00, 3, 0, 0, 0, 1, 1, 8'h11, 0, 0));
    tbl.push_back(mk(0, 0, 1, 8'h00, 2, 0, 0, 0, 0, 1, 8'h22, 0, 0));
    tbl.push_back(mk(0, 0, 1, 8'h00, 1, 0, 1, 0, 0, 1, 8'h33, 0, 0));
    tbl.push_back(mk(0, 0, 1, 8'h00, 0, 1, 1, 0, 0, 1, 8'h44, 0, 0));
    tbl.push_back(mk(0, 1, 0, 8'h11, 1, 0, 1, 0, 0, 0, 8'h44, 0, 0));
    tbl.push_back(mk(0, 1, 0, 8'h22, 2, 0, 0, 0, 0, 0, 8'h44, 0, 0));
    tbl.push_back(mk(0, 1, 0, 8'h33, 3, 0, 0, 0, 1, 0, 8'h44, 0, 0));
    tbl.push_back(mk(0, 1, 0, 8'h44, 4, 0, 0, 1, 1, 0, 8'h44, 0, 0));
    tbl.push_back(mk(0, 1, 1, 8'h55, 3, 0, 0, 0, 1, 1, 8'h11, 1, 0));
    tbl.push_back(mk(0, 0, 0, 8'h00, 3, 0, 0, 0, 1, 0, 8'h11, 0, 0));
    tbl.push_back(mk(0, 0, 1, 8'h00, 2, 0, 0, 0, 0, 1, 8'h22, 0, 0));
    tbl.push_back(mk(0, 0, 1, 8'h00, 1, 0, 1, 0, 0, 1, 8'h33, 0, 0));
    tbl.push_back(mk(0, 0, 1, 8'h00, 0, 1, 1, 0, 0, 1, 8'h44, 0, 0));
    tbl.push_back(mk(0, 1, 1, 8'hA5, 1, 0, 1, 0, 0, 0, 8'h44, 0, 1));
    tbl.push_back(mk(0, 0, 1, 8'h00, 0, 1, 1, 0, 0, 1, 8'hA5, 0, 0));
    tbl.push_back(mk(0, 1, 0, 8'h01, 1, 0, 1, 0, 0, 0, 8'hA5, 0, 0));
    tbl.push_back(mk(0, 1, 0, 8'h02, 2, 0, 0, 0, 0, 0, 8'hA5, 0, 0));
    tbl.push_back(mk(0, 1, 0, 8'h03, 3, 0, 0, 0, 1, 0, 8'hA5, 0, 0));
    tbl.push_back(mk(1, 1, 0, 8'h09, 0, 1, 1, 0, 0, 0, 8'hA5, 0, 0));
    tbl.push_back(mk(0, 0, 1, 8'h00, 0, 1, 1, 0, 0, 0, 8'hA5, 0, 1));

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].fl, tbl[i].wr, tbl[i].rd, tbl[i].din);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d.count", i), 32'(bus.count), 32'(tbl[i].cnt));
      chk($sformatf("vec%0d.empty", i), 32'(bus.empty), 32'(tbl[i].emp));
      chk($sformatf("vec%0d.almost_empty", i), 32'(bus.almost_empty), 32'(tbl[i].ae));
      chk($sformatf("vec%0d.full", i), 32'(bus.full), 32'(tbl[i].ful));
      chk($sformatf("vec%0d.almost_full", i), 32'(bus.almost_full), 32'(tbl[i].af));
      chk($sformatf("vec%0d.data_valid", i), 32'(bus.data_valid), 32'(tbl[i].dv));
      chk($sformatf("vec%0d.data_out", i), 32'(bus.data_out), 32'(tbl[i].dout));
      chk($sformatf("vec%0d.overflow", i), 32'(bus.overflow), 32'(tbl[i].ovf));
      chk($sformatf("vec%0d.underflow", i), 32'(bus.underflow), 32'(tbl[i].unf));
    end
`else
    drive(0, 1, 0, 8'h11);
    @(posedge clk); #1;
    chk("fwft.first.data_valid", 32'(bus.data_valid), 1);
    chk("fwft.first.data_out", 32'(bus.data_out), 32'h11);
    drive(0, 1, 0, 8'h22);
    @(posedge clk); #1;
    chk("fwft.second.data_out", 32'(bus.data_out), 32'h11);
    chk("fwft.second.count", 32'(bus.count), 2);
    drive(0, 0, 1, 8'h00);
    @(posedge clk); #1;
    chk("fwft.pop1.data_out", 32'(bus.data_out), 32'h22);
    chk("fwft.pop1.data_valid", 32'(bus.data_valid), 1);
    @(posedge clk); #1;
    chk("fwft.pop2.data_valid", 32'(bus.data_valid), 0);
    chk("fwft.pop2.empty", 32'(bus.empty), 1);
`endif

    // Asynchronous reset landing between edges during a write burst.
    drive(0, 1, 0, 8'h5A);
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    #1 check_reset_values("async_rst");
    drive(0, 0, 0, 8'h00);
    @(posedge clk);
    #1 rst = 1'b0;
    check_reset_values("after_rst");

    q.delete();
    m_dout = 8'h00;
    m_dv   = 1'b0;
    for (int n = 0; n < 400; n++) begin
      int wr_bias;
      wr_bias = (n < 200) ? 70 : 30;
      rand_step(n,
                $urandom_range(0, 99) < 3,
                $urandom_range(0, 99) < wr_bias,
                $urandom_range(0, 99) < (100 - wr_bias),
                8'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sync_fifo_param.md
# sync_fifo_param

Parametrised single-clock FIFO: the next-generation buffer for the datapath, with independent data width and depth, a true DEPTH-entry capacity, an occupancy count, programmable almost-empty and almost-full thresholds, a synchronous flush, and overflow/underflow pulses. It sits between a producer and a consumer in the same clock domain. A compile-time option selects first-word-fall-through read mode.

## Interface
- DW, 8: data width in bits (≥1).
- AW, 4: address width; DEPTH = 2**AW entries (AW ≥ 1).
- AE_LVL, 1: almost_empty asserts when count ≤ AE_LVL (0 ≤ AE_LVL < DEPTH).
- AF_LVL, 2**AW-1: almost_full asserts when count ≥ AF_LVL (1 ≤ AF_LVL ≤ DEPTH).

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous clear of FIFO contents.
- write_rq  in  1  write request.
- data_in  in  DW  write data.
- read_rq  in  1  read request.
- data_out  out  DW  read data.
- data_valid  out  1  data_out holds a valid popped word (see Operation).
- empty  out  1  count == 0.
- almost_empty  out  1  count ≤ AE_LVL.
- full  out  1  count == DEPTH.
- almost_full  out  1  count ≥ AF_LVL.
- count  out  AW+1  current occupancy, 0..DEPTH.
- overflow  out  1  one-cycle pulse: write_rq while full, write dropped.
- underflow  out  1  one-cycle pulse: read_rq while empty, read dropped.

## Operation
- Storage: DEPTH×DW array. The write and read pointers are AW+1 bits wide and wrap modulo 2·DEPTH. The low AW bits address the array. count = wr_ptr − rd_ptr (AW+1 bits).
- Acceptance: wr_acc = write_rq & ~full. rd_acc = read_rq & ~empty. Both are evaluated on the registered state at the start of the cycle.
- wr_acc writes data_in to mem[wr_ptr] and increments wr_ptr. rd_acc increments rd_ptr.
- Simultaneous accepted read and write: both pointers advance and count is unchanged.
- When full, write_rq with read_rq: the read is accepted, the write is rejected, and overflow pulses. The write is not retried.
- When empty, read_rq with write_rq: the write is accepted, the read is rejected, and underflow pulses.
- Flush: clears both pointers and count to 0 and data_valid to 0. data_out keeps its value. Flush overrides read and write in the same cycle: both are ignored and neither overflow nor underflow pulses.
- Status outputs (empty, almost_empty, full, almost_full, count) derive only from registered state. There is no combinational path from any input to any status output.
- overflow and underflow are registered: each asserts in the cycle after the offending edge, for exactly one cycle per offending request.
- Reset (any time, including mid-transfer): pointers = 0, count = 0, data_out = 0, data_valid = 0, empty = 1, almost_empty = 1, full = 0, almost_full = 0, overflow = 0, underflow = 0. Array contents are not reset.

## Timing
- Standard mode:
  - On the edge that performs rd_acc, data_out is loaded with mem[rd_ptr] and data_valid = 1 for the following cycle.
  - Otherwise data_valid = 0 and data_out holds.
  - Read latency is 1 cycle.
- Write-to-visibility: a word written at edge N raises count and clears empty after edge N. It is readable with read_rq in cycle N+1.
- Throughput: one write and one read per cycle sustained at any occupancy in 1..DEPTH−1.
- Flags update in the same cycle as count, one cycle after the accepting edge.

## Configuration
- SYNC_FIFO_FWFT_EN defined: first-word-fall-through mode.
  - data_out = mem[rd_ptr] combinationally from registered state.
  - data_valid = ~empty.
  - read_rq acts as a pop/acknowledge of the currently shown word. The next word, or the unchanged value if the FIFO goes empty, appears after the edge.
  - Read latency is 0 cycles.
  - At reset, data_valid = 0. data_out equals the unreset array head and carries no meaning.
- Not defined: standard registered-read mode, as described above.

## Test plan
- DW=8, AW=2 (DEPTH=4), standard mode: after reset, check count=0, empty=1, almost_empty=1, data_out=0x00, data_valid=0.
- Write 0x11, 0x22, 0x33, 0x44 on consecutive cycles, then assert read_rq for 4 cycles. Expect data_out = 0x11, 0x22, 0x33, 0x44, each with data_valid=1 one cycle after its read. Expect full=1 at count=4 and almost_full=1 from count=3.
- While full, assert write_rq (0x55) and read_rq together. The read returns 0x11. count goes 4→3. overflow pulses for 1 cycle. 0x55 is never read out.
- While empty, assert write_rq (0xA5) and read_rq together. count goes 0→1, underflow pulses for 1 cycle, data_valid stays 0. A following read returns 0xA5.
- Fill to count=3, assert flush with write_rq in the same cycle. Next cycle: count=0, empty=1, no overflow pulse. Raise rst mid-burst: all outputs return to their reset values asynchronously.
- SYNC_FIFO_FWFT_EN defined: write 0x11 then 0x22. data_out=0x11 with data_valid=1 one cycle after the first write, with no read_rq. After a read_rq edge, data_out=0x22. After a second read_rq edge, data_valid=0.
